// File: rtl/ocp2dbus_if.sv
// ocp2dbus_if: OCP slave-port and DBus device-port signals of the ocp2dbus bridge.
// Signal names carry the bridge's point of view: i_* flow into the bridge and
// o_* flow out of it. The slave modport is the bridge; the master modport is
// the surrounding fabric port plus the attached device.
interface ocp2dbus_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int BEN_WIDTH  = 4
);
    // OCP side
    logic [ADDR_WIDTH-1:0] i_MAddr;
    logic [2:0]            i_MCmd;
    logic [DATA_WIDTH-1:0] i_MData;
    logic [BEN_WIDTH-1:0]  i_MByteEn;
    logic                  o_SCmdAccept;
    logic [DATA_WIDTH-1:0] o_SData;
    logic [1:0]            o_SResp;
    // Device side
    logic [ADDR_WIDTH-1:0] o_DAddr;
    logic                  o_DCmd;
    logic                  o_DRnW;
    logic [BEN_WIDTH-1:0]  o_DBen;
    logic [DATA_WIDTH-1:0] o_DData;
    logic [DATA_WIDTH-1:0] i_DData;
    logic                  i_DRdy;
    logic                  i_DErr;

    modport slave (
        input  i_MAddr, i_MCmd, i_MData, i_MByteEn,
        output o_SCmdAccept, o_SData, o_SResp,
        output o_DAddr, o_DCmd, o_DRnW, o_DBen, o_DData,
        input  i_DData, i_DRdy, i_DErr
    );

    modport master (
        output i_MAddr, i_MCmd, i_MData, i_MByteEn,
        input  o_SCmdAccept, o_SData, o_SResp,
        input  o_DAddr, o_DCmd, o_DRnW, o_DBen, o_DData,
        output i_DData, i_DRdy, i_DErr
    );
endinterface

// File: rtl/ocp2dbus.sv
// ocp2dbus: OCP-to-DBus responder bridge, one outstanding transaction.
// Accepts OCP WR/RD in IDLE, issues a one-cycle device strobe, waits for
// i_DRdy/i_DErr and returns a single-cycle OCP response. Unsupported OCP
// commands are accepted and answered with ERR without touching the device.
// Optional feature macro: OCP2DBUS_TIMEOUT_EN forces an ERR response when the
// device stays silent for TIMEOUT_CYCLES counted CMD/WAIT cycles.
module ocp2dbus #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int BEN_WIDTH      = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    ocp2dbus_if.slave   bus
);

    localparam logic [2:0] MCMD_IDLE  = 3'd0;
    localparam logic [2:0] MCMD_WR    = 3'd1;
    localparam logic [2:0] MCMD_RD    = 3'd2;
    localparam logic [1:0] SRESP_NULL = 2'd0;
    localparam logic [1:0] SRESP_DVA  = 2'd1;
    localparam logic [1:0] SRESP_ERR  = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CMD  = 2'd1,
        S_WAIT = 2'd2,
        S_RESP = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_next;

    logic [ADDR_WIDTH-1:0] r_daddr, w_daddr;
    logic [DATA_WIDTH-1:0] r_ddata, w_ddata;
    logic [BEN_WIDTH-1:0]  r_dben,  w_dben;
    logic                  r_drnw,  w_drnw;
    logic                  r_dcmd,  w_dcmd;
    logic [1:0]            r_sresp, w_sresp;
    logic [DATA_WIDTH-1:0] r_sdata, w_sdata;
    logic                  w_timeout;

`ifdef OCP2DBUS_TIMEOUT_EN
    // Last counter value before the timeout fires: the TIMEOUT_CYCLES-th counted cycle.
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0] r_cnt;

    // Count CMD/WAIT cycles without completion; restart on each new command.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= 8'd0;
        end else if (r_state == S_IDLE && w_next == S_CMD) begin
            r_cnt <= 8'd0;
        end else if ((r_state == S_CMD || r_state == S_WAIT) &&
                     !(bus.i_DRdy || bus.i_DErr)) begin
            r_cnt <= r_cnt + 8'd1;
        end else begin
            r_cnt <= r_cnt;
        end
    end

    assign w_timeout = (r_state == S_CMD || r_state == S_WAIT) && (r_cnt == TO_LAST);
`else
    assign w_timeout = 1'b0;
`endif

    // Next-state and next-output decode; completions outside CMD/WAIT are ignored.
    always_comb begin
        w_next  = r_state;
        w_daddr = r_daddr;
        w_ddata = r_ddata;
        w_dben  = r_dben;
        w_drnw  = r_drnw;
        w_dcmd  = 1'b0;
        w_sresp = SRESP_NULL;
        w_sdata = {DATA_WIDTH{1'b0}};
        case (r_state)
            S_IDLE: begin
                if (bus.i_MCmd == MCMD_WR || bus.i_MCmd == MCMD_RD) begin
                    w_daddr = bus.i_MAddr;
                    w_ddata = bus.i_MData;
                    w_dben  = bus.i_MByteEn;
                    w_drnw  = (bus.i_MCmd == MCMD_RD);
                    w_dcmd  = 1'b1;
                    w_next  = S_CMD;
                end else if (bus.i_MCmd != MCMD_IDLE) begin
                    w_sresp = SRESP_ERR;
                    w_next  = S_RESP;
                end else begin
                    w_next  = S_IDLE;
                end
            end
            S_CMD, S_WAIT: begin
                if (bus.i_DErr) begin
                    // Error wins even when ready is raised in the same cycle.
                    w_sresp = SRESP_ERR;
                    w_next  = S_RESP;
                end else if (bus.i_DRdy) begin
                    w_sresp = SRESP_DVA;
                    w_sdata = r_drnw ? bus.i_DData : {DATA_WIDTH{1'b0}};
                    w_next  = S_RESP;
                end else if (w_timeout) begin
                    w_sresp = SRESP_ERR;
                    w_next  = S_RESP;
                end else begin
                    w_next  = S_WAIT;
                end
            end
            S_RESP: begin
                // Device-facing registers return to zero as the bridge re-enters IDLE.
                w_daddr = {ADDR_WIDTH{1'b0}};
                w_ddata = {DATA_WIDTH{1'b0}};
                w_dben  = {BEN_WIDTH{1'b0}};
                w_drnw  = 1'b0;
                w_next  = S_IDLE;
            end
            default: begin
                w_daddr = {ADDR_WIDTH{1'b0}};
                w_ddata = {DATA_WIDTH{1'b0}};
                w_dben  = {BEN_WIDTH{1'b0}};
                w_drnw  = 1'b0;
                w_next  = S_IDLE;
            end
        endcase
    end

    // State register and registered outputs; reset drops any in-flight transaction.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_daddr <= {ADDR_WIDTH{1'b0}};
            r_ddata <= {DATA_WIDTH{1'b0}};
            r_dben  <= {BEN_WIDTH{1'b0}};
            r_drnw  <= 1'b0;
            r_dcmd  <= 1'b0;
            r_sresp <= SRESP_NULL;
            r_sdata <= {DATA_WIDTH{1'b0}};
        end else begin
            r_state <= w_next;
            r_daddr <= w_daddr;
            r_ddata <= w_ddata;
            r_dben  <= w_dben;
            r_drnw  <= w_drnw;
            r_dcmd  <= w_dcmd;
            r_sresp <= w_sresp;
            r_sdata <= w_sdata;
        end
    end

    // Accept is combinational from state so IDLE accepts in the same cycle.
    assign bus.o_SCmdAccept = (r_state == S_IDLE) && !rst;
    assign bus.o_SResp      = r_sresp;
    assign bus.o_SData      = r_sdata;
    assign bus.o_DAddr      = r_daddr;
    assign bus.o_DData      = r_ddata;
    assign bus.o_DBen       = r_dben;
    assign bus.o_DRnW       = r_drnw;
    assign bus.o_DCmd       = r_dcmd;

endmodule

// File: tb/tb_ocp2dbus.sv
// tb_ocp2dbus: directed self-checking bench for the ocp2dbus bridge.
// Expected OCP responses are pushed into a scoreboard queue when a command is
// accepted and popped when the response cycle is reached.
module tb_ocp2dbus;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = 4;

    typedef struct packed {
        logic [1:0]    resp;
        logic [DW-1:0] data;
    } exp_t;

    logic clk;
    logic rst;
    int   n_pass;
    int   n_total;
    exp_t sb_q[$];

    ocp2dbus_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BEN_WIDTH(BW)) bus ();

    ocp2dbus #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BEN_WIDTH(BW), .TIMEOUT_CYCLES(4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case the sequence ever stalls.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic check_resp(input string tag);
        exp_t e;
        if (sb_q.size() == 0) begin
            n_total++;
            assert (bus.o_SResp === 2'd0) n_pass++;
            else $error("FAIL %s: unexpected response %0h with empty scoreboard", tag, bus.o_SResp);
        end else begin
            e = sb_q.pop_front();
            chk({tag, "_resp"}, 64'(bus.o_SResp), 64'(e.resp));
            chk({tag, "_data"}, 64'(bus.o_SData), 64'(e.data));
        end
    endtask

    task automatic drive_cmd(input logic [2:0] cmd, input logic [31:0] addr,
                             input logic [31:0] data, input logic [3:0] ben);
        bus.i_MCmd    = cmd;
        bus.i_MAddr   = addr;
        bus.i_MData   = data;
        bus.i_MByteEn = ben;
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        rst = 1'b1;
        drive_cmd(3'd0, 32'h0, 32'h0, 4'h0);
        bus.i_DData = 32'h0;
        bus.i_DRdy  = 1'b0;
        bus.i_DErr  = 1'b0;

        // Reset state
        cyc(); cyc();
        chk("rst_accept", 64'(bus.o_SCmdAccept), 64'd0);
        chk("rst_sresp",  64'(bus.o_SResp), 64'd0);
        chk("rst_dcmd",   64'(bus.o_DCmd), 64'd0);
        chk("rst_daddr",  64'(bus.o_DAddr), 64'd0);
        rst = 1'b0;
        cyc();
        chk("idle_accept", 64'(bus.o_SCmdAccept), 64'd1);

        // Read completing in CMD
        drive_cmd(3'd2, 32'h0000_0004, 32'h0, 4'hf);
        sb_q.push_back('{resp: 2'd1, data: 32'hf1f2_f3f4});
        cyc();
        drive_cmd(3'd0, 32'h0, 32'h0, 4'h0);
        chk("rd_dcmd",   64'(bus.o_DCmd), 64'd1);
        chk("rd_drnw",   64'(bus.o_DRnW), 64'd1);
        chk("rd_dben",   64'(bus.o_DBen), 64'hf);
        chk("rd_daddr",  64'(bus.o_DAddr), 64'h4);
        chk("rd_accept", 64'(bus.o_SCmdAccept), 64'd0);
        chk("rd_sresp0", 64'(bus.o_SResp), 64'd0);
        bus.i_DRdy = 1'b1;
        bus.i_DData = 32'hf1f2_f3f4;
        cyc();
        bus.i_DRdy = 1'b0;
        bus.i_DData = 32'h0;
        chk("rd_dcmd_off", 64'(bus.o_DCmd), 64'd0);
        check_resp("rd");
        cyc();
        chk("rd_idle_sresp", 64'(bus.o_SResp), 64'd0);
        chk("rd_idle_daddr", 64'(bus.o_DAddr), 64'd0);
        chk("rd_idle_drnw",  64'(bus.o_DRnW), 64'd0);
        chk("rd_idle_accept", 64'(bus.o_SCmdAccept), 64'd1);

        // Write completing after 3 wait cycles
        drive_cmd(3'd1, 32'h0000_0008, 32'hf5f6_f7f8, 4'h3);
        sb_q.push_back('{resp: 2'd1, data: 32'h0});
        cyc();
        drive_cmd(3'd0, 32'h0, 32'h0, 4'h0);
        chk("wr_dcmd",  64'(bus.o_DCmd), 64'd1);
        chk("wr_drnw",  64'(bus.o_DRnW), 64'd0);
        chk("wr_ddata", 64'(bus.o_DData), 64'hf5f6_f7f8);
        for (int i = 0; i < 2; i++) begin
            cyc();
            chk("wr_wait_dcmd",  64'(bus.o_DCmd), 64'd0);
            chk("wr_wait_ddata", 64'(bus.o_DData), 64'hf5f6_f7f8);
            chk("wr_wait_dben",  64'(bus.o_DBen), 64'h3);
            chk("wr_wait_sresp", 64'(bus.o_SResp), 64'd0);
        end
        cyc();
        chk("wr_wait3_ddata", 64'(bus.o_DData), 64'hf5f6_f7f8);
        bus.i_DRdy = 1'b1;
        bus.i_DData = 32'hdead_beef;
        cyc();
        bus.i_DRdy = 1'b0;
        bus.i_DData = 32'h0;
        check_resp("wr");
        cyc();
        chk("wr_idle_ddata", 64'(bus.o_DData), 64'd0);
        chk("wr_idle_dben",  64'(bus.o_DBen), 64'd0);

        // Ready and error together: error wins
        drive_cmd(3'd2, 32'h0000_000c, 32'h0, 4'hf);
        sb_q.push_back('{resp: 2'd3, data: 32'h0});
        cyc();
        drive_cmd(3'd0, 32'h0, 32'h0, 4'h0);
        bus.i_DRdy = 1'b1;
        bus.i_DErr = 1'b1;
        bus.i_DData = 32'h1234_5678;
        cyc();
        bus.i_DRdy = 1'b0;
        bus.i_DErr = 1'b0;
        bus.i_DData = 32'h0;
        check_resp("both");
        cyc();

        // Unsupported command: ERR next cycle, no device strobe
        drive_cmd(3'd5, 32'h0000_0040, 32'h0, 4'hf);
        chk("bad_accept", 64'(bus.o_SCmdAccept), 64'd1);
        sb_q.push_back('{resp: 2'd3, data: 32'h0});
        cyc();
        drive_cmd(3'd0, 32'h0, 32'h0, 4'h0);
        chk("bad_dcmd", 64'(bus.o_DCmd), 64'd0);
        check_resp("bad");
        cyc();
        chk("bad_idle_dcmd", 64'(bus.o_DCmd), 64'd0);

        // Back-to-back RD then WR held by master
        drive_cmd(3'd2, 32'h0000_0010, 32'h0, 4'hf);
        sb_q.push_back('{resp: 2'd1, data: 32'ha5a5_a5a5});
        cyc();
        drive_cmd(3'd1, 32'h0000_0014, 32'h1122_3344, 4'hf);
        chk("b2b_cmd_accept", 64'(bus.o_SCmdAccept), 64'd0);
        chk("b2b_cmd_drnw", 64'(bus.o_DRnW), 64'd1);
        cyc();
        chk("b2b_wait_accept", 64'(bus.o_SCmdAccept), 64'd0);
        chk("b2b_wait_daddr", 64'(bus.o_DAddr), 64'h10);
        bus.i_DRdy = 1'b1;
        bus.i_DData = 32'ha5a5_a5a5;
        cyc();
        bus.i_DRdy = 1'b0;
        bus.i_DData = 32'h0;
        chk("b2b_resp_accept", 64'(bus.o_SCmdAccept), 64'd0);
        check_resp("b2b_rd");
        cyc();
        chk("b2b_idle_accept", 64'(bus.o_SCmdAccept), 64'd1);
        sb_q.push_back('{resp: 2'd1, data: 32'h0});
        cyc();
        drive_cmd(3'd0, 32'h0, 32'h0, 4'h0);
        chk("b2b_wr_daddr", 64'(bus.o_DAddr), 64'h14);
        chk("b2b_wr_drnw",  64'(bus.o_DRnW), 64'd0);
        chk("b2b_wr_ddata", 64'(bus.o_DData), 64'h1122_3344);
        bus.i_DRdy = 1'b1;
        cyc();
        bus.i_DRdy = 1'b0;
        check_resp("b2b_wr");
        cyc();

        // Reset during WAIT drops the transaction
        drive_cmd(3'd2, 32'h0000_0020, 32'h0, 4'hf);
        cyc();
        drive_cmd(3'd0, 32'h0, 32'h0, 4'h0);
        cyc();
        chk("rstw_daddr", 64'(bus.o_DAddr), 64'h20);
        rst = 1'b1;
        cyc();
        chk("rstw_daddr0", 64'(bus.o_DAddr), 64'd0);
        chk("rstw_drnw0",  64'(bus.o_DRnW), 64'd0);
        chk("rstw_dben0",  64'(bus.o_DBen), 64'd0);
        chk("rstw_sresp0", 64'(bus.o_SResp), 64'd0);
        chk("rstw_accept0", 64'(bus.o_SCmdAccept), 64'd0);
        rst = 1'b0;
        bus.i_DRdy = 1'b1;
        bus.i_DData = 32'h5555_aaaa;
        cyc();
        chk("rstw_late_sresp", 64'(bus.o_SResp), 64'd0);
        bus.i_DRdy = 1'b0;
        bus.i_DData = 32'h0;
        cyc();
        chk("rstw_late_sresp2", 64'(bus.o_SResp), 64'd0);
        chk("rstw_accept", 64'(bus.o_SCmdAccept), 64'd1);

        // Silent device: timeout ERR when enabled, otherwise stuck in WAIT
        drive_cmd(3'd2, 32'h0000_0030, 32'h0, 4'hf);
`ifdef OCP2DBUS_TIMEOUT_EN
        sb_q.push_back('{resp: 2'd3, data: 32'h0});
`endif
        cyc();
        drive_cmd(3'd0, 32'h0, 32'h0, 4'h0);
        for (int i = 0; i < 4; i++) begin
            chk("to_quiet_sresp", 64'(bus.o_SResp), 64'd0);
            cyc();
        end
`ifdef OCP2DBUS_TIMEOUT_EN
        check_resp("to");
        cyc();
        bus.i_DRdy = 1'b1;
        bus.i_DData = 32'h7777_7777;
        cyc();
        bus.i_DRdy = 1'b0;
        bus.i_DData = 32'h0;
        chk("to_late_sresp", 64'(bus.o_SResp), 64'd0);
        chk("to_late_accept", 64'(bus.o_SCmdAccept), 64'd1);
`else
        for (int i = 0; i < 4; i++) begin
            chk("nto_sresp", 64'(bus.o_SResp), 64'd0);
            chk("nto_accept", 64'(bus.o_SCmdAccept), 64'd0);
            cyc();
        end
        sb_q.push_back('{resp: 2'd1, data: 32'h0bad_cafe});
        bus.i_DRdy = 1'b1;
        bus.i_DData = 32'h0bad_cafe;
        cyc();
        bus.i_DRdy = 1'b0;
        bus.i_DData = 32'h0;
        check_resp("nto");
        cyc();
        chk("nto_idle_accept", 64'(bus.o_SCmdAccept), 64'd1);
`endif

        chk("sb_empty", 64'(sb_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/ocp2dbus.md
# ocp2dbus

OCP-to-DBus responder bridge: the slave-side counterpart of `dbus2ocp2`. It terminates one OCP slave port of `fabric2` and drives a simple DBus-style device interface (address, command strobe, read/not-write, byte enables, data, ready/error). Peripherals can then hang off a fabric port without their own OCP logic. It handles one outstanding transaction, with an optional response timeout.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 255: cycles counted from the DCmd strobe before an error response is forced. Used only with `OCP2DBUS_TIMEOUT_EN`. Legal range 2..255.

Ports (clock and reset first):
- `clk`  in  1  system clock; all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `i_MAddr`  in  `ADDR_WIDTH`  OCP request address
- `i_MCmd`  in  3  OCP command: 0 IDLE, 1 WR, 2 RD, others unsupported
- `i_MData`  in  `DATA_WIDTH`  OCP write data
- `i_MByteEn`  in  `BEN_WIDTH`  OCP byte enables
- `o_SCmdAccept`  out  1  command accepted this cycle
- `o_SData`  out  `DATA_WIDTH`  OCP read data
- `o_SResp`  out  2  OCP response: 0 NULL, 1 DVA, 3 ERR
- `o_DAddr`  out  `ADDR_WIDTH`  device address (registered)
- `o_DCmd`  out  1  device command strobe, one cycle
- `o_DRnW`  out  1  1 = read, 0 = write
- `o_DBen`  out  `BEN_WIDTH`  device byte enables
- `o_DData`  out  `DATA_WIDTH`  device write data
- `i_DData`  in  `DATA_WIDTH`  device read data, valid with `i_DRdy`
- `i_DRdy`  in  1  device completion
- `i_DErr`  in  1  device error completion

## Operation
- FSM states:
  - IDLE: `o_SCmdAccept` = 1, combinational; this is the only state that accepts.
    - `i_MCmd` WR/RD: latch addr/data/ben/RnW, go to CMD.
    - `i_MCmd` 3..7: accept, go to RESP with ERR. No device access.
    - `i_MCmd` IDLE: stay.
  - CMD: `o_DCmd` = 1 for exactly this cycle; address/data/ben/RnW held from the latch.
    - Sample `i_DRdy`/`i_DErr`. On either, go to RESP; else go to WAIT.
  - WAIT: `o_DCmd` = 0, device outputs held.
    - Sample `i_DRdy`/`i_DErr`. On either, go to RESP.
  - RESP: `o_SResp` driven for exactly one cycle, then go to IDLE.
- Response value:
  - `i_DErr` wins over `i_DRdy` when both are high: ERR.
  - Otherwise `i_DRdy`: DVA.
- Read data:
  - On a DVA read, `o_SData` = `i_DData` captured on the completing edge.
  - On writes or ERR, `o_SData` = 0.
- Writes are non-posted; every accepted command produces exactly one response.
- `i_DRdy`/`i_DErr` arriving in IDLE or RESP are ignored.
- `o_DAddr`/`o_DData`/`o_DBen` return to 0 when entering IDLE. `o_DRnW` returns to 0.
- Reset mid-transaction: FSM goes to IDLE and the transaction is dropped with no response. Device completions arriving afterward are ignored.

## Timing
- Reset values: `o_SCmdAccept` = 0 while `rst` is high, then 1 (IDLE). All other outputs 0, `o_SResp` = NULL.
- Latency for a device that completes in CMD, with accept in cycle N:
  - cycle N+1: CMD
  - cycle N+2: RESP
- General latency: SResp in cycle N+2+k, where k = device wait cycles.
- Unsupported command accepted in N: ERR in N+1.
- Throughput: at most one transaction per 3 cycles. A command presented during CMD/WAIT/RESP sees `o_SCmdAccept` = 0 and must be held by the master.

## Configuration
- `OCP2DBUS_TIMEOUT_EN` defined:
  - 8-bit counter clears on entry to CMD and increments in each CMD/WAIT cycle without completion.
  - When it reaches `TIMEOUT_CYCLES`, go to RESP with ERR and `o_SData` = 0.
  - A completion in the same cycle as the timeout takes precedence over the timeout.
- Not defined: no counter; WAIT can last indefinitely.

## Test plan
- Read, device `i_DRdy` in CMD with `i_DData` = 32'hf1f2_f3f4, addr 32'h0000_0004 → `o_DCmd` one cycle with `o_DRnW` = 1, `o_DBen` = 4'hf; SResp DVA with SData 32'hf1f2_f3f4 two cycles after accept.
- Write 32'hf5f6_f7f8 to 32'h0000_0008, ben 4'h3, device ready after 3 wait cycles → `o_DData`/`o_DBen` held through WAIT; DVA 5 cycles after accept; SData 0.
- `i_DRdy` and `i_DErr` both high → SResp ERR; MCmd = 3'd5 → accepted, ERR next cycle, `o_DCmd` never asserted.
- Back-to-back RD then WR held by master → second accept only in the cycle after the first RESP; `o_SCmdAccept` low in CMD/WAIT/RESP.
- `rst` pulsed during WAIT → all outputs 0 the next cycle; a later `i_DRdy` produces no SResp.
- With `OCP2DBUS_TIMEOUT_EN` and `TIMEOUT_CYCLES` = 4, device silent → ERR after 4 counted cycles; late `i_DRdy` in IDLE ignored. Without the macro, the same stimulus stays in WAIT.
